// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the digital clock: mode encodings, field moduli
// and field widths, plus the mode-advance rule used by the top-level FSM.
package clock_ctrl_pkg;

  // Mode encodings as they appear on the mode output; 2'd3 is never produced.
  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;

  // Field moduli and widths.
  localparam int SEC_MAX   = 60;
  localparam int MIN_MAX   = 60;
  localparam int SEC_BITS  = 6;
  localparam int MIN_BITS  = 6;
  localparam int HOUR_BITS = 5;

  // Mode sequence RUN -> SET_HOUR -> SET_MIN -> RUN, advanced by btn_mode.
  // The unused encoding falls back to RUN so the FSM cannot lock up.
  function automatic logic [1:0] next_mode(input logic [1:0] cur,
                                           input logic       adv);
    logic [1:0] nxt;
    nxt = cur;
    if (adv) begin
      case (cur)
        MODE_RUN:      nxt = MODE_SET_HOUR;
        MODE_SET_HOUR: nxt = MODE_SET_MIN;
        default:       nxt = MODE_RUN;
      endcase
    end else if (cur == 2'd3) begin
      nxt = MODE_RUN;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/clock_ctrl_mod_counter.sv
// Modulo-MAX counter with enable and synchronous clear. carry flags the
// enabled cycle in which the counter wraps, so cascaded fields roll over
// on the same clock edge.
module mod_counter #(
  parameter int MAX  = 60,
  parameter int BITS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  output logic [BITS-1:0] value,
  output logic            carry
);

  localparam logic [BITS-1:0] LAST = BITS'(MAX - 1);

  // Count state: cleared by reset or clr, advances and wraps when enabled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= (value == LAST) ? '0 : value + 1'b1;
    end
  end

  assign carry = en && (value == LAST);

endmodule

// File: rtl/clock_ctrl.sv
// Digital clock top: 1 s prescaler, RUN/SET_HOUR/SET_MIN mode FSM, and the
// enable/carry steering that drives the sec, min and hour counters.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 50000000,
  parameter int HOUR_MAX = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_mode,
  input  logic                 btn_inc,
  output logic [SEC_BITS-1:0]  sec,
  output logic [MIN_BITS-1:0]  min,
  output logic [HOUR_BITS-1:0] hour,
  output logic [1:0]           mode,
  output logic                 tick,
  output logic                 blink
);

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_tick;
  logic          r_blink;
  logic [1:0]    r_mode;
  logic [1:0]    w_next_mode;
  logic          w_run;
  logic          w_exit_set;
  logic          w_inc_ok;
  logic          w_sec_en;
  logic          w_min_en;
  logic          w_hour_en;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic          w_unused_hour_carry;

  assign w_next_mode = next_mode(r_mode, btn_mode);
  assign w_run       = (r_mode == MODE_RUN);
  // Leaving SET_MIN restarts the second from zero, sec and prescaler alike.
  assign w_exit_set  = (r_mode == MODE_SET_MIN) && btn_mode;
  // A mode press wins over a simultaneous increment press.
  assign w_inc_ok    = btn_inc && !btn_mode;

  // Next prescaler count: wrap at CLK_DIV-1, restart on leaving SET_MIN.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_presc_next = r_presc + 1'b1;
    if (w_exit_set || (r_presc == PRESC_LAST)) begin
      w_presc_next = '0;
    end
  end

  // Prescaler and registered tick; tick is high exactly while the count is CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_next;
      r_tick  <= (w_presc_next == PRESC_LAST);
    end
  end

  // Mode FSM register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_RUN;
    end else begin
      r_mode <= w_next_mode;
    end
  end

  // Blink: held low in and on entry to RUN, starts low on entry to SET_HOUR
  // (from RUN), toggles on each tick while in a SET mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink <= 1'b0;
    end else if (w_run || (w_next_mode == MODE_RUN)) begin
      r_blink <= 1'b0;
    end else if (r_tick) begin
      r_blink <= ~r_blink;
    end
  end

  // Field enables: time-of-day carries in RUN, button increments in SET modes.
  // In SET_MIN the minute carry is not routed to hour.
  assign w_sec_en  = w_run && r_tick;
  assign w_min_en  = w_run ? w_sec_carry
                           : ((r_mode == MODE_SET_MIN) && w_inc_ok);
  assign w_hour_en = w_run ? w_min_carry
                           : ((r_mode == MODE_SET_HOUR) && w_inc_ok);

  mod_counter #(.MAX(SEC_MAX), .BITS(SEC_BITS)) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (w_sec_en),
    .clr   (w_exit_set),
    .value (sec),
    .carry (w_sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .BITS(MIN_BITS)) u_min (
    .clk   (clk),
    .reset (reset),
    .en    (w_min_en),
    .clr   (1'b0),
    .value (min),
    .carry (w_min_carry)
  );

  mod_counter #(.MAX(HOUR_MAX), .BITS(HOUR_BITS)) u_hour (
    .clk   (clk),
    .reset (reset),
    .en    (w_hour_en),
    .clr   (1'b0),
    .value (hour),
    .carry (w_unused_hour_carry)
  );

  assign mode  = r_mode;
  assign tick  = r_tick;
  assign blink = r_blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with CLK_DIV=4, HOUR_MAX=24. Outputs are
// sampled 1 time unit after each rising edge; edge numbers in comments are
// counted from the most recent prescaler clear.
module tb_clock_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       tick;
  logic       blink;

  int n_assert = 0;
  int n_fail   = 0;

  clock_ctrl #(.CLK_DIV(4), .HOUR_MAX(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .mode     (mode),
    .tick     (tick),
    .blink    (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m,
                            input int s);
    check({tag, ".hour"}, 32'(hour), 32'(h));
    check({tag, ".min"},  32'(min),  32'(m));
    check({tag, ".sec"},  32'(sec),  32'(s));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
      step();
    end
  endtask

  initial begin
    int n_ticks;
    int first_tick;
    int bad_period;

    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    n_ticks    = 0;
    first_tick = -1;
    bad_period = 0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check_time("reset", 0, 0, 0);
    check("reset.mode",  32'(mode),  32'd0);
    check("reset.tick",  32'(tick),  32'd0);
    check("reset.blink", 32'(blink), 32'd0);
    step();
    step();
    reset = 1'b0;

    // 240 cycles in RUN: ticks on edges 3,7,..,239; 60 seconds -> 00:01:00.
    for (int i = 1; i <= 240; i++) begin
      step();
      if (tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
        if ((i % 4) != 3) bad_period++;
      end
      if (i == 4) check("run.first_sec", 32'(sec), 32'd1);
    end
    check("run.first_tick", 32'(first_tick), 32'd3);
    check("run.n_ticks", 32'(n_ticks), 32'd60);
    check("run.tick_period", 32'(bad_period), 32'd0);
    check_time("run240", 0, 1, 0);
    check("run.blink", 32'(blink), 32'd0);

    // SET_HOUR: 25 increments wrap 0 -> 1, min/sec untouched.
    pulse_mode();
    check("set_hour.mode",  32'(mode),  32'd1);
    check("set_hour.blink", 32'(blink), 32'd0);
    pulse_inc(25);
    check_time("hour_x25", 1, 1, 0);

    // SET_MIN: bring min to 0, then 61 increments -> min=1, no hour carry.
    pulse_mode();
    check("set_min.mode", 32'(mode), 32'd2);
    pulse_inc(59);
    check_time("min_wrap0", 1, 0, 0);
    pulse_inc(61);
    check_time("min_x61", 1, 1, 0);

    // Preload 23:59.
    pulse_inc(58);
    pulse_mode();
    check("back_run.mode", 32'(mode), 32'd0);
    pulse_mode();
    pulse_inc(22);
    check("preload.hour", 32'(hour), 32'd23);
    pulse_mode();
    check("preload.mode", 32'(mode), 32'd2);

    // SET_MIN -> RUN at edge E: sec and prescaler cleared, tick at E+3.
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("exit.mode", 32'(mode), 32'd0);
    check("exit.tick_e0", 32'(tick), 32'd0);
    check_time("exit", 23, 59, 0);
    step();
    check("exit.tick_e1", 32'(tick), 32'd0);
    step();
    check("exit.tick_e2", 32'(tick), 32'd0);
    step();
    check("exit.tick_e3", 32'(tick), 32'd1);

    // Run to E+239 (23:59:59), then single-edge rollover at E+240.
    repeat (236) step();
    check_time("pre_roll", 23, 59, 59);
    step();
    check_time("rollover", 0, 0, 0);

    // Preload 10:20, return to RUN at E2, run 120 cycles -> 10:20:30.
    pulse_mode();
    pulse_inc(10);
    pulse_mode();
    pulse_inc(20);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check_time("preload2", 10, 20, 0);
    repeat (120) step();
    check_time("t102030", 10, 20, 30);

    // btn_inc on E2+121..123 (no tick in those cycles): time unchanged.
    btn_inc = 1'b1;
    step();
    check_time("run_inc1", 10, 20, 30);
    step();
    check_time("run_inc2", 10, 20, 30);
    step();
    check_time("run_inc3", 10, 20, 30);
    btn_inc = 1'b0;
    check("run_inc.tick", 32'(tick), 32'd1);
    step();
    check_time("run_tick", 10, 20, 31);

    // btn_mode+btn_inc at E2+125 in RUN: enter SET_HOUR, hour unchanged.
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check("both_run.mode", 32'(mode), 32'd1);
    check_time("both_run", 10, 20, 31);
    check("both_run.blink", 32'(blink), 32'd0);

    // Blink toggles on the edge after each tick: 1 at E2+128, 0 at E2+132.
    repeat (3) step();
    check("blink.on", 32'(blink), 32'd1);
    repeat (4) step();
    check("blink.off", 32'(blink), 32'd0);

    // btn_mode+btn_inc in SET_HOUR (E2+133): SET_MIN, hour unchanged.
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step();
    check("both_sh.mode", 32'(mode), 32'd2);
    check_time("both_sh", 10, 20, 31);

    // btn_mode+btn_inc in SET_MIN (E2+134): RUN, min unchanged, sec cleared.
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check("both_sm.mode", 32'(mode), 32'd0);
    check_time("both_sm", 10, 20, 0);
    check("both_sm.blink", 32'(blink), 32'd0);
    check("both_sm.tick", 32'(tick), 32'd0);

    // Reset mid-cycle while in SET_MIN after partial setting.
    pulse_mode();
    pulse_mode();
    pulse_inc(3);
    check("mid_set.mode", 32'(mode), 32'd2);
    check("mid_set.min", 32'(min), 32'd23);
    step();
    #3 reset = 1'b1;
    #1;
    check_time("async_rst", 0, 0, 0);
    check("async_rst.mode",  32'(mode),  32'd0);
    check("async_rst.tick",  32'(tick),  32'd0);
    check("async_rst.blink", 32'(blink), 32'd0);
    step();
    reset = 1'b0;

    // First tick after release on the third edge, time still 00:00:00.
    step();
    step();
    check("post_rst.tick_e2", 32'(tick), 32'd0);
    step();
    check("post_rst.tick_e3", 32'(tick), 32'd1);
    check_time("post_rst", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
